// File: rtl/mem_interface_pkg.sv
// Shared encodings and helpers for the byte-serial memory interface.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package mem_defs;

    // Request size encodings
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Direction encodings
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Sequencer state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_READ   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Request attributes kept for the whole sequence
    typedef struct packed {
        logic [1:0] size;
        logic       sign_ext;
    } req_t;

    // Number of RAM bytes touched by a request of the given size
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

    // Illegal size or misaligned base address
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SIZE_ILLEGAL) ||
               ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_interface_if.sv
// Control-unit side of the memory interface: request fields plus MOV/MFC handshake.
// Latency: none (wires only).
// Backpressure: busy high means further mov strobes are ignored.
interface mem_interface_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              mov;
    logic              rw;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mfc;
    logic              err;
    logic              busy;

    // Control unit drives the request and observes completion
    modport master (
        output mov, rw, size, sign_ext, addr, wdata,
        input  rdata, mfc, err, busy
    );

    // Memory interface consumes the request and reports completion
    modport slave (
        input  mov, rw, size, sign_ext, addr, wdata,
        output rdata, mfc, err, busy
    );
endinterface

// File: rtl/mem_interface_load_extend.sv
// Zero/sign extension of an assembled big-endian load to the full word.
// Latency: combinational.
// Backpressure: none.
module load_extend
    import mem_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] asm_dat,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] ext_dat
);

    // Replicate bit 7 or bit 15 when sign extension is requested; words pass through
    always_comb begin
        ext_dat = asm_dat;
        case (size)
            SIZE_BYTE: ext_dat = {{(DATA_W-8){sign_ext & asm_dat[7]}}, asm_dat[7:0]};
            SIZE_HALF: ext_dat = {{(DATA_W-16){sign_ext & asm_dat[15]}}, asm_dat[15:0]};
            default:   ext_dat = asm_dat;
        endcase
    end

endmodule

// File: rtl/mem_interface.sv
// Splits byte/half/word loads and stores into single-byte RAM accesses, MSB first.
// Latency: store N, load N+1, rejected request 1 edge(s) from acceptance to mfc.
// Backpressure: one request at a time; mov ignored unless idle, busy flags the sequence.
module mem_interface
    import mem_defs::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              main_clk,
    input  logic              reset,
    mem_interface_if.slave    bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    logic [1:0]        state_q,     state_d;
    logic [2:0]        k_q,         k_d;
    logic [ADDR_W-1:0] base_q,      base_d;
    req_t              req_q,       req_d;
    logic              err_pend_q,  err_pend_d;
    logic [DATA_W-9:0] wsh_q,       wsh_d;
    logic [DATA_W-9:0] asm_q,       asm_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              mfc_q,       mfc_d;
    logic              err_q,       err_d;
    logic              busy_q,      busy_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic              ram_we_q,    ram_we_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;

    logic [2:0]        n_bytes;
    logic [2:0]        k_inc;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] wdata_aligned;
    logic [DATA_W-1:0] asm_shift;
    logic [DATA_W-1:0] load_ext;
    logic              req_bad;

    assign n_bytes   = size_bytes(req_q.size);
    assign k_inc     = k_q + 3'd1;
    assign next_addr = base_q + {{(ADDR_W-3){1'b0}}, k_inc};
    assign asm_shift = {asm_q, ram_rdata};
    assign req_bad   = req_illegal(bus.size, bus.addr[1:0]);

    // Left-justify the used store bytes so the first byte out is always the top byte
    always_comb begin
        wdata_aligned = bus.wdata;
        case (bus.size)
            SIZE_BYTE: wdata_aligned = {bus.wdata[7:0],  {(DATA_W-8){1'b0}}};
            SIZE_HALF: wdata_aligned = {bus.wdata[15:0], {(DATA_W-16){1'b0}}};
            default:   wdata_aligned = bus.wdata;
        endcase
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .asm_dat  (asm_shift),
        .size     (req_q.size),
        .sign_ext (req_q.sign_ext),
        .ext_dat  (load_ext)
    );

    // Sequencer: accept, walk the bytes, then hold a single mfc cycle
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        base_d      = base_q;
        req_d       = req_q;
        err_pend_d  = err_pend_q;
        wsh_d       = wsh_q;
        asm_d       = asm_q;
        rdata_d     = rdata_q;
        mfc_d       = 1'b0;
        err_d       = err_q;
        busy_d      = busy_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.mov) begin
                    req_d.size     = bus.size;
                    req_d.sign_ext = bus.sign_ext;
                    base_d         = bus.addr;
                    k_d            = 3'd0;
                    asm_d          = '0;
                    busy_d         = 1'b1;
                    err_pend_d     = req_bad;
                    state_d        = (bus.rw == RW_READ) ? ST_READ : ST_WRITE;
                    // Rejected requests never drive the RAM
                    if (!req_bad) begin
                        ram_addr_d = bus.addr;
                        if (bus.rw == RW_WRITE) begin
                            ram_we_d    = 1'b1;
                            ram_wdata_d = wdata_aligned[DATA_W-1 -: 8];
                            wsh_d       = wdata_aligned[DATA_W-9:0];
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (err_pend_q || (k_q == n_bytes - 3'd1)) begin
                    state_d = ST_FINISH;
                    mfc_d   = 1'b1;
                    err_d   = err_pend_q;
                    busy_d  = 1'b0;
                end else begin
                    k_d         = k_inc;
                    ram_addr_d  = next_addr;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = wsh_q[DATA_W-9 -: 8];
                    wsh_d       = {wsh_q[DATA_W-17:0], 8'h00};
                end
            end

            ST_READ: begin
                if (err_pend_q) begin
                    state_d = ST_FINISH;
                    mfc_d   = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    // Byte for address k-1 arrives one cycle after that address
                    if (k_q != 3'd0) begin
                        asm_d = asm_shift[DATA_W-9:0];
                    end
                    if (k_q == n_bytes) begin
                        rdata_d = load_ext;
                        state_d = ST_FINISH;
                        mfc_d   = 1'b1;
                        err_d   = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        k_d = k_inc;
                        if (k_inc < n_bytes) begin
                            ram_addr_d = next_addr;
                        end
                    end
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= 3'd0;
            base_q      <= '0;
            req_q       <= '0;
            err_pend_q  <= 1'b0;
            wsh_q       <= '0;
            asm_q       <= '0;
            rdata_q     <= '0;
            mfc_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            base_q      <= base_d;
            req_q       <= req_d;
            err_pend_q  <= err_pend_d;
            wsh_q       <= wsh_d;
            asm_q       <= asm_d;
            rdata_q     <= rdata_d;
            mfc_q       <= mfc_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.mfc   = mfc_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: behavioural 512x8 RAM, shadow memory reference model.
// Latency: expectations derived from byte counts (store N, load N+1, error 1).
// Backpressure: requests issued one at a time, plus one run with mov held high.
`timescale 1ns/1ps
module tb_mem_interface;
    import mem_defs::*;

    logic main_clk = 1'b0;
    logic reset;
    always #5 main_clk = ~main_clk;

    mem_interface_if #(.ADDR_W(9), .DATA_W(32)) bus ();

    logic [8:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    mem_interface #(.ADDR_W(9), .DATA_W(32)) dut (
        .main_clk  (main_clk),
        .reset     (reset),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Behavioural synchronous RAM plus activity monitors
    logic [7:0] mem    [512];
    logic [7:0] shadow [512];
    logic       pl_we = 1'b0;
    logic [8:0] pl_addr = '0;
    logic [7:0] pl_dat = '0;
    int         we_cnt = 0;
    int         mfc_cnt = 0;
    logic [8:0] last_we_addr = '0;

    always @(posedge main_clk) begin
        if (pl_we) mem[pl_addr] <= pl_dat;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (ram_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= ram_addr;
        end
        if (bus.mfc) mfc_cnt <= mfc_cnt + 1;
    end

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_rdata = '0;

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_bad(input logic [1:0] s, input logic [8:0] a);
        return (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] s, input logic sg, input logic [8:0] a);
        logic [31:0] v = 0;
        int n = nbytes(s);
        for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, shadow[int'(a) + i]};
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] s, input logic [8:0] a, input logic [31:0] wd);
        int n = nbytes(s);
        for (int i = 0; i < n; i++) shadow[int'(a) + i] = 8'(wd >> (8*(n-1-i)));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic poke(input logic [8:0] a, input logic [7:0] d);
        @(negedge main_clk);
        pl_we = 1'b1; pl_addr = a; pl_dat = d;
        shadow[a] = d;
        @(posedge main_clk);
        #1 pl_we = 1'b0;
    endtask

    task automatic do_req(input logic rw, input logic [1:0] s, input logic sg,
                          input logic [8:0] a, input logic [31:0] wd,
                          output int lat, output logic err_o, output logic [31:0] rd_o,
                          output int nwe, output int nmfc, output logic busy_bad,
                          output logic we_in_mfc);
        int we0, m0;
        @(negedge main_clk);
        bus.mov = 1'b1; bus.rw = rw; bus.size = s; bus.sign_ext = sg;
        bus.addr = a; bus.wdata = wd;
        we0 = we_cnt; m0 = mfc_cnt;
        @(posedge main_clk);
        #1 bus.mov = 1'b0;
        lat = 0; busy_bad = !bus.busy;
        while (lat < 20) begin
            @(posedge main_clk); #1;
            lat++;
            if (bus.mfc) break;
            if (!bus.busy) busy_bad = 1'b1;
        end
        err_o = bus.err; rd_o = bus.rdata; we_in_mfc = ram_we;
        if (bus.busy) busy_bad = 1'b1;
        @(posedge main_clk); #1;
        nwe = we_cnt - we0; nmfc = mfc_cnt - m0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests++;
        if ({bus.rdata, bus.mfc, bus.err, bus.busy} !== 35'h0) begin
            failed++; $display("FAIL reset_bus got %h want 0", {bus.rdata, bus.mfc, bus.err, bus.busy});
        end
        tests++;
        if ({ram_we, ram_addr, ram_wdata} !== 18'h0) begin
            failed++; $display("FAIL reset_ram got %h want 0", {ram_we, ram_addr, ram_wdata});
        end
    endtask

    task automatic test_word_load();
        int lat, nwe, nm; logic e, bb, wim; logic [31:0] rd;
        poke(9'd52, 8'h80); poke(9'd53, 8'h00); poke(9'd54, 8'h00); poke(9'd55, 8'h05);
        do_req(RW_READ, SIZE_WORD, 1'b1, 9'd52, 32'h0, lat, e, rd, nwe, nm, bb, wim);
        exp_rdata = model_load(SIZE_WORD, 1'b1, 9'd52);
        tests++; if (lat !== 5) begin failed++; $display("FAIL wload_lat got %0d want 5", lat); end
        tests++; if (rd !== 32'h8000_0005) begin failed++; $display("FAIL wload_data got %h want 80000005", rd); end
        tests++; if (e !== 1'b0) begin failed++; $display("FAIL wload_err got %b want 0", e); end
        tests++; if (nwe !== 0) begin failed++; $display("FAIL wload_we got %0d want 0", nwe); end
        tests++; if (bb !== 1'b0 || nm !== 1) begin failed++; $display("FAIL wload_busy_mfc got bb=%b nmfc=%0d want 0/1", bb, nm); end
    endtask

    task automatic test_byte_ext();
        int lat, nwe, nm; logic e, bb, wim; logic [31:0] rd;
        poke(9'd53, 8'hF0);
        do_req(RW_READ, SIZE_BYTE, 1'b1, 9'd53, 32'h0, lat, e, rd, nwe, nm, bb, wim);
        tests++; if (lat !== 2) begin failed++; $display("FAIL bload_lat got %0d want 2", lat); end
        tests++; if (rd !== 32'hFFFF_FFF0) begin failed++; $display("FAIL bload_sext got %h want fffffff0", rd); end
        do_req(RW_READ, SIZE_BYTE, 1'b0, 9'd53, 32'h0, lat, e, rd, nwe, nm, bb, wim);
        tests++; if (rd !== 32'h0000_00F0) begin failed++; $display("FAIL bload_zext got %h want 000000f0", rd); end
        exp_rdata = 32'h0000_00F0;
    endtask

    task automatic test_store_top();
        int lat, nwe, nm; logic e, bb, wim; logic [31:0] rd;
        do_req(RW_WRITE, SIZE_WORD, 1'b0, 9'd508, 32'h1122_3344, lat, e, rd, nwe, nm, bb, wim);
        model_store(SIZE_WORD, 9'd508, 32'h1122_3344);
        tests++; if (lat !== 4) begin failed++; $display("FAIL wstore_lat got %0d want 4", lat); end
        tests++; if ({mem[508], mem[509], mem[510], mem[511]} !== 32'h1122_3344) begin
            failed++; $display("FAIL wstore_ram got %h want 11223344", {mem[508], mem[509], mem[510], mem[511]}); end
        tests++; if (nwe !== 4 || wim !== 1'b0 || e !== 1'b0) begin
            failed++; $display("FAIL wstore_we got nwe=%0d we_mfc=%b err=%b want 4/0/0", nwe, wim, e); end
        tests++; if (last_we_addr !== 9'd511) begin failed++; $display("FAIL wstore_lastaddr got %0d want 511", last_we_addr); end
        tests++; if (mem[0] !== shadow[0] || mem[1] !== shadow[1]) begin
            failed++; $display("FAIL wstore_nowrap got %h%h want %h%h", mem[0], mem[1], shadow[0], shadow[1]); end
    endtask

    task automatic test_misaligned();
        int lat, nwe, nm; logic e, bb, wim; logic [31:0] rd;
        do_req(RW_READ, SIZE_HALF, 1'b1, 9'd51, 32'h0, lat, e, rd, nwe, nm, bb, wim);
        tests++; if (lat !== 1 || e !== 1'b1) begin failed++; $display("FAIL mis_half got lat=%0d err=%b want 1/1", lat, e); end
        tests++; if (rd !== exp_rdata) begin failed++; $display("FAIL mis_half_rdata got %h want %h", rd, exp_rdata); end
        tests++; if (bus.err !== 1'b1) begin failed++; $display("FAIL err_hold got %b want 1", bus.err); end
        do_req(RW_WRITE, SIZE_WORD, 1'b0, 9'd50, 32'hDEAD_BEEF, lat, e, rd, nwe, nm, bb, wim);
        tests++; if (lat !== 1 || e !== 1'b1 || nwe !== 0) begin
            failed++; $display("FAIL mis_word got lat=%0d err=%b nwe=%0d want 1/1/0", lat, e, nwe); end
        tests++; if ({mem[50], mem[51], mem[52], mem[53]} !== {shadow[50], shadow[51], shadow[52], shadow[53]}) begin
            failed++; $display("FAIL mis_word_ram got %h", {mem[50], mem[51], mem[52], mem[53]}); end
        do_req(RW_READ, SIZE_ILLEGAL, 1'b0, 9'd40, 32'h0, lat, e, rd, nwe, nm, bb, wim);
        tests++; if (lat !== 1 || e !== 1'b1 || rd !== exp_rdata) begin
            failed++; $display("FAIL illegal_size got lat=%0d err=%b rd=%h want 1/1/%h", lat, e, rd, exp_rdata); end
    endtask

    task automatic test_reset_mid_store();
        int m0;
        poke(9'd0, 8'h00); poke(9'd1, 8'h00); poke(9'd2, 8'h5A); poke(9'd3, 8'hA5);
        @(negedge main_clk);
        bus.mov = 1'b1; bus.rw = RW_WRITE; bus.size = SIZE_WORD; bus.sign_ext = 1'b0;
        bus.addr = 9'd0; bus.wdata = 32'hAABB_CCDD;
        @(posedge main_clk); #1 bus.mov = 1'b0;
        @(posedge main_clk);
        @(posedge main_clk);
        #2 reset = 1'b1;
        m0 = mfc_cnt;
        #1;
        tests++;
        if ({bus.rdata, bus.mfc, bus.err, bus.busy, ram_we, ram_addr, ram_wdata} !== 53'h0) begin
            failed++; $display("FAIL midreset_out got %h want 0",
                               {bus.rdata, bus.mfc, bus.err, bus.busy, ram_we, ram_addr, ram_wdata}); end
        repeat (4) @(posedge main_clk);
        @(negedge main_clk) reset = 1'b0;
        repeat (3) @(posedge main_clk);
        #1;
        shadow[0] = 8'hAA; shadow[1] = 8'hBB;
        exp_rdata = '0;
        tests++; if (mfc_cnt !== m0) begin failed++; $display("FAIL midreset_mfc got %0d want %0d", mfc_cnt, m0); end
        tests++; if ({mem[0], mem[1], mem[2], mem[3]} !== {shadow[0], shadow[1], shadow[2], shadow[3]}) begin
            failed++; $display("FAIL midreset_ram got %h want %h", {mem[0], mem[1], mem[2], mem[3]},
                               {shadow[0], shadow[1], shadow[2], shadow[3]}); end
    endtask

    task automatic test_back_to_back();
        int L = 4;
        int we0, m0;
        logic [12:1] mfc_seen, busy_seen, mfc_exp, busy_exp;
        logic [31:0] wd = $urandom;
        @(negedge main_clk);
        bus.mov = 1'b1; bus.rw = RW_WRITE; bus.size = SIZE_WORD; bus.sign_ext = 1'b0;
        bus.addr = 9'd8; bus.wdata = wd;
        we0 = we_cnt; m0 = mfc_cnt;
        @(posedge main_clk);
        for (int e = 1; e <= 12; e++) begin
            @(posedge main_clk); #1;
            mfc_seen[e]  = bus.mfc;
            busy_seen[e] = bus.busy;
            mfc_exp[e]   = (e == L) || (e == 2*L + 2);
            busy_exp[e]  = (e < L) || (e >= L + 2 && e < 2*L + 2);
            if (e == L + 2) bus.mov = 1'b0;
        end
        model_store(SIZE_WORD, 9'd8, wd);
        tests++; if (mfc_seen !== mfc_exp) begin failed++; $display("FAIL b2b_mfc got %b want %b", mfc_seen, mfc_exp); end
        tests++; if (busy_seen !== busy_exp) begin failed++; $display("FAIL b2b_busy got %b want %b", busy_seen, busy_exp); end
        tests++; if (we_cnt - we0 !== 8 || mfc_cnt - m0 !== 2) begin
            failed++; $display("FAIL b2b_count got we=%0d mfc=%0d want 8/2", we_cnt - we0, mfc_cnt - m0); end
        tests++; if ({mem[8], mem[9], mem[10], mem[11]} !== wd) begin
            failed++; $display("FAIL b2b_ram got %h want %h", {mem[8], mem[9], mem[10], mem[11]}, wd); end
    endtask

    task automatic test_random();
        int lat, nwe, nm, n, lat_exp, nwe_exp; logic e, bb, wim, bad; logic [31:0] rd;
        logic rw, sg; logic [1:0] s; logic [8:0] a; logic [31:0] wd;
        for (int it = 0; it < 60; it++) begin
            rw = 1'($urandom); sg = 1'($urandom);
            s  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 9'($urandom_range(0, 60));
            n  = nbytes(s);
            if ($urandom_range(0, 3) != 0) a = a - 9'(a % n);
            wd = $urandom;
            bad = is_bad(s, a);
            lat_exp = bad ? 1 : (rw ? n + 1 : n);
            nwe_exp = (bad || rw) ? 0 : n;
            if (!bad && rw) exp_rdata = model_load(s, sg, a);
            do_req(rw, s, sg, a, wd, lat, e, rd, nwe, nm, bb, wim);
            if (!bad && !rw) model_store(s, a, wd);
            tests++; if (lat !== lat_exp) begin failed++; $display("FAIL rnd%0d_lat got %0d want %0d", it, lat, lat_exp); end
            tests++; if (e !== bad) begin failed++; $display("FAIL rnd%0d_err got %b want %b", it, e, bad); end
            tests++; if (rd !== exp_rdata) begin failed++; $display("FAIL rnd%0d_rdata got %h want %h", it, rd, exp_rdata); end
            tests++; if (nwe !== nwe_exp || bb !== 1'b0) begin
                failed++; $display("FAIL rnd%0d_we got nwe=%0d bb=%b want %0d/0", it, nwe, bb, nwe_exp); end
            tests++; if ({mem[a], mem[a+1], mem[a+2], mem[a+3]} !== {shadow[a], shadow[a+1], shadow[a+2], shadow[a+3]}) begin
                failed++; $display("FAIL rnd%0d_ram got %h want %h", it, {mem[a], mem[a+1], mem[a+2], mem[a+3]},
                                   {shadow[a], shadow[a+1], shadow[a+2], shadow[a+3]}); end
        end
    endtask

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.mov = 1'b0; bus.rw = RW_READ; bus.size = SIZE_BYTE; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        repeat (2) @(posedge main_clk);
        #1 test_reset();
        @(negedge main_clk) reset = 1'b0;
        for (int i = 0; i < 64; i++) poke(9'(i), 8'($urandom));
        for (int i = 508; i < 512; i++) poke(9'(i), 8'h00);
        test_word_load();
        test_byte_ext();
        test_store_top();
        test_misaligned();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
